// File: rtl/uart_rx_engine.sv
// UART receive engine: configurable width, runtime parity, 1/2 stop bits,
// 3-sample majority vote per bit, valid/ready output with overrun pulse.
// Optional break detection is compiled in with UART_RX_BREAK_DETECT_EN.
module uart_rx_engine #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     divider,
  input  logic                 enable,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic                 break_detect,
`endif
  output logic                 busy
);

  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam int unsigned MID   = OVERSAMPLE / 2;

  localparam logic [OS_W-1:0]  S_EARLY  = OS_W'(MID - 1);
  localparam logic [OS_W-1:0]  S_MID    = OS_W'(MID);
  localparam logic [OS_W-1:0]  S_LATE   = OS_W'(MID + 1);
  localparam logic [OS_W-1:0]  S_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

`ifdef UART_RX_BREAK_DETECT_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_SHIFT, ST_PARITY, ST_STOP, ST_BREAK
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_SHIFT, ST_PARITY, ST_STOP
  } state_t;
`endif

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;
  logic                   fall_c;

  logic [DIV_W-1:0]     div_cnt;
  logic [DIV_W-1:0]     div_sh;
  logic                 par_sh;
  logic                 odd_sh;
  logic                 two_sh;
  logic                 tick_c;

  logic [OS_W-1:0]      os_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 s_early;
  logic                 s_mid;
  logic                 maj_c;
  logic                 decide_c;

  logic [DATA_BITS-1:0] shift_reg;
  logic                 perr_q;
  logic                 ferr_q;

  logic start_c, shift_c, par_c, stop_c, commit_c;
  logic bit_inc_c, bit_clr_c, os_clr_c, brk_c;

`ifdef UART_RX_BREAK_DETECT_EN
  logic par_zero;
  logic zero_c;
  assign zero_c = (shift_reg == '0) && par_zero;
`endif

  // Metastability synchroniser and edge detector on rx (idles high)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign fall_c = rx_prev & ~rx_s;

  // Shadow configuration, frozen for the duration of a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_sh <= '0;
      par_sh <= 1'b0;
      odd_sh <= 1'b0;
      two_sh <= 1'b0;
    end else if (start_c) begin
      div_sh <= divider;
      par_sh <= parity_en;
      odd_sh <= parity_odd;
      two_sh <= two_stop;
    end
  end

  assign tick_c = enable && (state != ST_IDLE) && (div_cnt == div_sh);

  // Sample-tick divider, held at 0 while idle or disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!enable || state == ST_IDLE || tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Tick position within the current bit period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt <= '0;
    end else if (os_clr_c) begin
      os_cnt <= '0;
    end else if (tick_c) begin
      os_cnt <= (os_cnt == S_LAST) ? '0 : os_cnt + OS_W'(1);
    end
  end

  // Early and middle samples; the late sample is taken live at decision time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else if (tick_c) begin
      if (os_cnt == S_EARLY) s_early <= rx_s;
      if (os_cnt == S_MID)   s_mid   <= rx_s;
    end
  end

  assign maj_c    = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);
  assign decide_c = tick_c && (os_cnt == S_LATE);

  // Bit counter, shared between data bits and stop bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (bit_clr_c) begin
      bit_cnt <= '0;
    end else if (bit_inc_c) begin
      bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  // Data shift register and per-frame error accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      if (start_c) begin
        perr_q <= 1'b0;
        ferr_q <= 1'b0;
      end
      if (shift_c) shift_reg <= {maj_c, shift_reg[DATA_BITS-1:1]};
      if (par_c)   perr_q    <= maj_c ^ (^shift_reg) ^ odd_sh;
      if (stop_c && !maj_c) ferr_q <= 1'b1;
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  // Tracks whether the parity bit (if any) was also sampled low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_zero <= 1'b1;
    end else if (start_c) begin
      par_zero <= 1'b1;
    end else if (par_c) begin
      par_zero <= ~maj_c;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // FSM next-state and control strobes
  always_comb begin
    state_n   = state;
    start_c   = 1'b0;
    shift_c   = 1'b0;
    par_c     = 1'b0;
    stop_c    = 1'b0;
    commit_c  = 1'b0;
    bit_inc_c = 1'b0;
    bit_clr_c = 1'b0;
    os_clr_c  = 1'b0;
    brk_c     = 1'b0;
    if (!enable) begin
      state_n   = ST_IDLE;
      os_clr_c  = 1'b1;
      bit_clr_c = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          os_clr_c  = 1'b1;
          bit_clr_c = 1'b1;
          if (fall_c) begin
            state_n = ST_START;
            start_c = 1'b1;
          end
        end
        ST_START: begin
          if (tick_c && os_cnt == S_MID && rx_s) begin
            state_n = ST_IDLE;
          end else if (tick_c && os_cnt == S_LAST) begin
            state_n = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (decide_c) begin
            shift_c = 1'b1;
            if (bit_cnt == BIT_LAST) begin
              bit_clr_c = 1'b1;
              state_n   = par_sh ? ST_PARITY : ST_STOP;
            end else begin
              bit_inc_c = 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (decide_c) begin
            par_c   = 1'b1;
            state_n = ST_STOP;
          end
        end
        ST_STOP: begin
          if (decide_c) begin
            stop_c = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
            if (bit_cnt == '0 && !maj_c && zero_c) begin
              brk_c    = 1'b1;
              commit_c = 1'b1;
              state_n  = ST_BREAK;
            end else
`endif
            if (two_sh && bit_cnt == '0) begin
              bit_inc_c = 1'b1;
            end else begin
              commit_c = 1'b1;
              state_n  = ST_IDLE;
            end
          end
        end
`ifdef UART_RX_BREAK_DETECT_EN
        ST_BREAK: begin
          // Need one full bit period of continuous high before resyncing
          if (!rx_s) begin
            os_clr_c = 1'b1;
          end else if (tick_c && os_cnt == S_LAST) begin
            state_n = ST_IDLE;
          end
        end
`endif
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Output word register with valid/ready handshake and overrun pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data          <= '0;
      valid         <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      break_detect  <= 1'b0;
`endif
    end else begin
      overrun_error <= 1'b0;
      if (commit_c) begin
        if (valid && !ready) begin
          overrun_error <= 1'b1;
        end else begin
          data          <= brk_c ? '0 : shift_reg;
          valid         <= 1'b1;
          parity_error  <= perr_q;
          framing_error <= ferr_q | ~maj_c;
`ifdef UART_RX_BREAK_DETECT_EN
          break_detect  <= brk_c;
`endif
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

  // Busy mirrors the state the FSM is about to occupy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= 1'b0;
    else     busy <= (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: vector table plus hand-written corner cases.
module tb_uart_rx_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] divider;
  logic        enable, parity_en, parity_odd, two_stop, rx, ready;
  logic [7:0]  data;
  logic        valid, parity_error, framing_error, overrun_error, busy;
`ifdef UART_RX_BREAK_DETECT_EN
  logic        break_detect;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int ov_cnt = 0;
  int vr_cnt = 0;
  logic valid_q = 1'b0;

  uart_rx_engine dut (
    .clk(clk), .rst(rst), .divider(divider), .enable(enable),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .rx(rx), .data(data), .valid(valid), .ready(ready),
    .parity_error(parity_error), .framing_error(framing_error),
    .overrun_error(overrun_error),
`ifdef UART_RX_BREAK_DETECT_EN
    .break_detect(break_detect),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Event monitors sampled on the inactive edge
  always @(negedge clk) begin
    if (overrun_error) ov_cnt = ov_cnt + 1;
    if (valid && !valid_q) vr_cnt = vr_cnt + 1;
    valid_q = valid;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       po;
    logic       pbit;
    logic       ts;
    logic       s1;
    logic       s2;
    logic [7:0] xd;
    logic       xpe;
    logic       xfe;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    rx = b;
    if (glitch) begin
      repeat (9) @(negedge clk);
      rx = ~b;
      @(negedge clk);
      rx = b;
      repeat (6) @(negedge clk);
    end else begin
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                            input logic ts, input logic s1, input logic s2,
                            input int gbit);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], (i == gbit));
    if (pe) send_bit(pbit, 1'b0);
    send_bit(s1, 1'b0);
    if (ts) send_bit(s2, 1'b0);
  endtask

  task automatic accept(input string name);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check(name, 32'(valid), 32'd0);
  endtask

  initial begin
    int base_ov, base_vr;
    logic [7:0] w;

    vecs[0] = '{8'hA5, 0, 0, 0, 0, 1, 1, 8'hA5, 0, 0};
    vecs[1] = '{8'h07, 1, 0, 0, 0, 1, 1, 8'h07, 1, 0};
    vecs[2] = '{8'h07, 1, 0, 1, 0, 1, 1, 8'h07, 0, 0};
    vecs[3] = '{8'h3C, 0, 0, 0, 1, 1, 0, 8'h3C, 0, 1};
    vecs[4] = '{8'h5A, 1, 1, 1, 0, 1, 1, 8'h5A, 0, 0};
    vecs[5] = '{8'hFF, 1, 1, 0, 0, 1, 1, 8'hFF, 1, 0};
    vecs[6] = '{8'h01, 0, 0, 0, 0, 0, 1, 8'h01, 0, 1};
    vecs[7] = '{8'h80, 0, 0, 0, 1, 1, 1, 8'h80, 0, 0};
    vecs[8] = '{8'h00, 1, 0, 0, 0, 1, 1, 8'h00, 0, 0};

    rst = 1'b1; rx = 1'b1; ready = 1'b0; enable = 1'b1; divider = 16'd0;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_errs", {29'd0, parity_error, framing_error, overrun_error}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Latency: valid rises exactly one clk after the stop-bit decision
    w = 8'hA5;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = w[i];
      repeat (16) @(negedge clk);
    end
    rx = 1'b1;
    repeat (12) @(negedge clk);
    check("lat_valid_before", 32'(valid), 32'd0);
    check("lat_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat_valid_after", 32'(valid), 32'd1);
    check("lat_data", 32'(data), 32'hA5);
    repeat (20) @(negedge clk);
    accept("lat_accept");

    // Table-driven frames
    for (int i = 0; i < 9; i++) begin
      base_ov = ov_cnt;
      parity_en = vecs[i].pe; parity_odd = vecs[i].po; two_stop = vecs[i].ts;
      send_frame(vecs[i].d, vecs[i].pe, vecs[i].pbit, vecs[i].ts,
                 vecs[i].s1, vecs[i].s2, -1);
      rx = 1'b1;
      repeat (24) @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'd1);
      check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].xd));
      check($sformatf("vec%0d_perr", i), 32'(parity_error), 32'(vecs[i].xpe));
      check($sformatf("vec%0d_ferr", i), 32'(framing_error), 32'(vecs[i].xfe));
      check($sformatf("vec%0d_ovr", i), 32'(ov_cnt - base_ov), 32'd0);
      accept($sformatf("vec%0d_accept", i));
    end
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;

    // Short start glitch: OVERSAMPLE/4 ticks low, no frame
    base_vr = vr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_start_novalid", 32'(vr_cnt - base_vr), 32'd0);
    check("glitch_start_idle", 32'(busy), 32'd0);

    // One-clk glitch at a data mid-sample is voted out
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3);
    rx = 1'b1;
    repeat (24) @(negedge clk);
    check("vote_valid", 32'(valid), 32'd1);
    check("vote_data", 32'(data), 32'h55);
    check("vote_ferr", 32'(framing_error), 32'd0);
    accept("vote_accept");

    // Overrun: back-to-back frames with ready held low
    base_ov = ov_cnt;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    rx = 1'b1;
    repeat (24) @(negedge clk);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_data_kept", 32'(data), 32'h11);
    check("ovr_pulses", 32'(ov_cnt - base_ov), 32'd1);
    accept("ovr_accept");

    // enable dropped mid-frame discards the partial word
    base_vr = vr_cnt;
    w = 8'h33;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = w[i];
      repeat (16) @(negedge clk);
    end
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("en_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("en_novalid", 32'(vr_cnt - base_vr), 32'd0);

    // Reset midway through data bit 4 while a word is held
    send_frame(8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    w = 8'h6B;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = w[i];
      repeat (16) @(negedge clk);
    end
    rx = w[4];
    repeat (8) @(negedge clk);
    check("pre_rst_valid", 32'(valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    rx = 1'b1;
    repeat (40) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    rx = 1'b1;
    repeat (24) @(negedge clk);
    check("post_rst_valid", 32'(valid), 32'd1);
    check("post_rst_data", 32'(data), 32'h81);
    check("post_rst_ferr", 32'(framing_error), 32'd0);
    accept("post_rst_accept");

`ifdef UART_RX_BREAK_DETECT_EN
    // Long break: one break word, then one clean frame after resync
    base_vr = vr_cnt;
    rx = 1'b0;
    repeat (320) @(negedge clk);
    check("brk_valid", 32'(valid), 32'd1);
    check("brk_flag", 32'(break_detect), 32'd1);
    check("brk_data", 32'(data), 32'd0);
    check("brk_ferr", 32'(framing_error), 32'd1);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    accept("brk_accept");
    send_frame(8'h42, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    rx = 1'b1;
    repeat (24) @(negedge clk);
    check("brk_next_data", 32'(data), 32'h42);
    check("brk_next_flag", 32'(break_detect), 32'd0);
    check("brk_frames", 32'(vr_cnt - base_vr), 32'd2);
    accept("brk_next_accept");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
